// File: rtl/u_dispatcher.sv
// rtl/u_dispatcher.sv - in-order ID-stage issue controller with WFI/HALT handling and perf counters
module u_dispatcher #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instBuffer_dispatcher_inst_vld,
    input  logic                 idu_dispatcher_stall_vld,
    input  logic                 idu_dispatcher_wfi_vld,
    input  logic                 idu_dispatcher_exception_illegal_inst,
    input  logic                 idu_dispatcher_rd_vld,
    input  logic                 idu_dispatcher_dmem_load,
    input  logic                 iex_dispatcher_flush,
    input  logic                 irq_dispatcher_wakeup,
    output logic                 dispatcher_instBuffer_pop,
    output logic                 dispatcher_ifu_pc_hold,
    output logic                 dispatcher_iex_pipe_vld,
    output logic                 dispatcher_iex_rd_vld,
    output logic                 dispatcher_iex_is_load,
    output logic                 dispatcher_wfi_sleep,
    output logic                 dispatcher_exception_vld,
    output logic [CNT_WIDTH-1:0] dispatcher_perf_issue_cnt,
    output logic [CNT_WIDTH-1:0] dispatcher_perf_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WFI  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   pop;
    logic   pc_hold;
    logic   issue;
    logic   stall_evt;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        pc_hold    = 1'b1;
        issue      = 1'b0;
        stall_evt  = 1'b0;
        case (state)
            ST_RUN: begin
                // A flush discards the wrong-path instruction regardless of its decode.
                if (iex_dispatcher_flush) begin
                    pop = instBuffer_dispatcher_inst_vld;
                end else if (!instBuffer_dispatcher_inst_vld) begin
                    pop = 1'b0;
                end else if (idu_dispatcher_exception_illegal_inst) begin
                    next_state = ST_HALT;
                end else if (idu_dispatcher_stall_vld) begin
                    stall_evt = 1'b1;
                end else if (idu_dispatcher_wfi_vld) begin
                    pop        = 1'b1;
                    next_state = ST_WFI;
                end else begin
                    pop   = 1'b1;
                    issue = 1'b1;
                end
                pc_hold = instBuffer_dispatcher_inst_vld & ~pop;
            end
            ST_WFI: begin
                if (irq_dispatcher_wakeup) begin
                    next_state = ST_RUN;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    assign dispatcher_instBuffer_pop = pop;
    assign dispatcher_ifu_pc_hold    = pc_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                     <= ST_RUN;
            dispatcher_iex_pipe_vld   <= 1'b0;
            dispatcher_iex_rd_vld     <= 1'b0;
            dispatcher_iex_is_load    <= 1'b0;
            dispatcher_wfi_sleep      <= 1'b0;
            dispatcher_exception_vld  <= 1'b0;
            dispatcher_perf_issue_cnt <= '0;
            dispatcher_perf_stall_cnt <= '0;
        end else begin
            state                    <= next_state;
            dispatcher_iex_pipe_vld  <= issue;
            dispatcher_iex_rd_vld    <= issue & idu_dispatcher_rd_vld;
            dispatcher_iex_is_load   <= issue & idu_dispatcher_dmem_load;
            dispatcher_wfi_sleep     <= (next_state == ST_WFI);
            dispatcher_exception_vld <= (next_state == ST_HALT);
            if (issue && (dispatcher_perf_issue_cnt != {CNT_WIDTH{1'b1}})) begin
                dispatcher_perf_issue_cnt <= dispatcher_perf_issue_cnt + 1'b1;
            end
            if (stall_evt && (dispatcher_perf_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                dispatcher_perf_stall_cnt <= dispatcher_perf_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_u_dispatcher.sv
// tb/tb_u_dispatcher.sv - directed self-checking bench for u_dispatcher
module tb_u_dispatcher;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_vld, stall_vld, wfi_vld, illegal, rd_vld, dmem_load, flush, wakeup;
    logic          pop, pc_hold, pipe_vld, iex_rd_vld, is_load, wfi_sleep, exc_vld;
    logic [CW-1:0] issue_cnt, stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    u_dispatcher #(.CNT_WIDTH(CW)) dut (
        .clk                                   (clk),
        .rst_n                                 (rst_n),
        .instBuffer_dispatcher_inst_vld        (inst_vld),
        .idu_dispatcher_stall_vld              (stall_vld),
        .idu_dispatcher_wfi_vld                (wfi_vld),
        .idu_dispatcher_exception_illegal_inst (illegal),
        .idu_dispatcher_rd_vld                 (rd_vld),
        .idu_dispatcher_dmem_load              (dmem_load),
        .iex_dispatcher_flush                  (flush),
        .irq_dispatcher_wakeup                 (wakeup),
        .dispatcher_instBuffer_pop             (pop),
        .dispatcher_ifu_pc_hold                (pc_hold),
        .dispatcher_iex_pipe_vld               (pipe_vld),
        .dispatcher_iex_rd_vld                 (iex_rd_vld),
        .dispatcher_iex_is_load                (is_load),
        .dispatcher_wfi_sleep                  (wfi_sleep),
        .dispatcher_exception_vld              (exc_vld),
        .dispatcher_perf_issue_cnt             (issue_cnt),
        .dispatcher_perf_stall_cnt             (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        inst_vld = 0; stall_vld = 0; wfi_vld = 0; illegal = 0;
        rd_vld = 0; dmem_load = 0; flush = 0; wakeup = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pipe"}, {31'd0, pipe_vld}, 0);
        chk({tag, "_rd"}, {31'd0, iex_rd_vld}, 0);
        chk({tag, "_ld"}, {31'd0, is_load}, 0);
        chk({tag, "_wfi"}, {31'd0, wfi_sleep}, 0);
        chk({tag, "_exc"}, {31'd0, exc_vld}, 0);
        chk({tag, "_icnt"}, {28'd0, issue_cnt}, 0);
        chk({tag, "_scnt"}, {28'd0, stall_cnt}, 0);
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        cyc();
        cyc();
        rst_n = 1;
        chk_reset_state("rst");

        // 4 back-to-back ALU issues
        for (int i = 0; i < 4; i++) begin
            inst_vld = 1; rd_vld = 1;
            #1 chk("b2b_pop", {31'd0, pop}, 1);
            chk("b2b_hold", {31'd0, pc_hold}, 0);
            cyc();
            chk("b2b_pipe", {31'd0, pipe_vld}, 1);
            chk("b2b_rd", {31'd0, iex_rd_vld}, 1);
        end
        inst_vld = 0; rd_vld = 0;
        #1 chk("idle_hold", {31'd0, pc_hold}, 0);
        cyc();
        chk("b2b_bubble", {31'd0, pipe_vld}, 0);
        chk("b2b_icnt", {28'd0, issue_cnt}, 4);
        chk("b2b_scnt", {28'd0, stall_cnt}, 0);

        // load-use stall
        do_reset();
        inst_vld = 1; rd_vld = 1; dmem_load = 1;
        cyc();
        chk("ld_isload", {31'd0, is_load}, 1);
        dmem_load = 0; stall_vld = 1;
        #1 chk("stall_pop", {31'd0, pop}, 0);
        chk("stall_hold", {31'd0, pc_hold}, 1);
        cyc();
        chk("stall_bubble", {31'd0, pipe_vld}, 0);
        chk("stall_scnt", {28'd0, stall_cnt}, 1);
        stall_vld = 0;
        #1 chk("dep_pop", {31'd0, pop}, 1);
        cyc();
        chk("dep_pipe", {31'd0, pipe_vld}, 1);
        chk("dep_isload", {31'd0, is_load}, 0);
        chk("dep_icnt", {28'd0, issue_cnt}, 2);
        chk("dep_scnt", {28'd0, stall_cnt}, 1);

        // WFI with wakeup on the third sleep cycle
        do_reset();
        inst_vld = 1; wfi_vld = 1;
        #1 chk("wfi_pop", {31'd0, pop}, 1);
        cyc();
        chk("wfi_sleep0", {31'd0, wfi_sleep}, 1);
        chk("wfi_pipe0", {31'd0, pipe_vld}, 0);
        wfi_vld = 0;
        for (int i = 0; i < 3; i++) begin
            wakeup = (i == 2);
            #1 chk("sleep_pop", {31'd0, pop}, 0);
            chk("sleep_hold", {31'd0, pc_hold}, 1);
            cyc();
            chk("sleep_state", {31'd0, wfi_sleep}, (i == 2) ? 0 : 1);
            chk("sleep_pipe", {31'd0, pipe_vld}, 0);
        end
        wakeup = 0;
        #1 chk("wake_pop", {31'd0, pop}, 1);
        cyc();
        chk("wake_pipe", {31'd0, pipe_vld}, 1);
        chk("wake_icnt", {28'd0, issue_cnt}, 1);

        // illegal instruction halts until reset
        do_reset();
        inst_vld = 1; illegal = 1;
        #1 chk("ill_pop", {31'd0, pop}, 0);
        chk("ill_hold", {31'd0, pc_hold}, 1);
        cyc();
        chk("ill_exc", {31'd0, exc_vld}, 1);
        illegal = 0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("halt_pop", {31'd0, pop}, 0);
            cyc();
            chk("halt_exc", {31'd0, exc_vld}, 1);
            chk("halt_pipe", {31'd0, pipe_vld}, 0);
        end
        chk("halt_icnt", {28'd0, issue_cnt}, 0);
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk("halt_rst_exc", {31'd0, exc_vld}, 0);

        // flush beats illegal and wfi
        do_reset();
        inst_vld = 1; flush = 1; illegal = 1;
        #1 chk("fl_ill_pop", {31'd0, pop}, 1);
        chk("fl_ill_hold", {31'd0, pc_hold}, 0);
        cyc();
        chk("fl_ill_exc", {31'd0, exc_vld}, 0);
        chk("fl_ill_pipe", {31'd0, pipe_vld}, 0);
        illegal = 0; wfi_vld = 1;
        #1 chk("fl_wfi_pop", {31'd0, pop}, 1);
        cyc();
        chk("fl_wfi_sleep", {31'd0, wfi_sleep}, 0);
        chk("fl_wfi_pipe", {31'd0, pipe_vld}, 0);
        chk("fl_wfi_exc", {31'd0, exc_vld}, 0);
        flush = 0; wfi_vld = 0;
        cyc();
        chk("fl_run_pipe", {31'd0, pipe_vld}, 1);

        // saturation, then reset during a stall
        do_reset();
        inst_vld = 1; rd_vld = 1; dmem_load = 1;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_icnt", {28'd0, issue_cnt}, 15);
        chk("sat_pipe", {31'd0, pipe_vld}, 1);
        stall_vld = 1;
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk_reset_state("rst_stall");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/u_dispatcher.md
# u_dispatcher

In-order issue controller for the single-issue ID stage. It sits between the instruction buffer, the IDU decode/bypass logic and the ID/EX pipeline register. Each cycle it decides whether the decoded instruction issues, is held for a load-use stall, is squashed by a redirect, parks the core in WFI, or halts it on an illegal instruction. It also drives the EX-stage valid, is_load and rd_vld flags that feed back into the IDU bypass selection, and keeps two saturating performance counters.

## Interface
- CNT_WIDTH, 32, width of each performance counter

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- instBuffer_dispatcher_inst_vld  in  1  instruction buffer holds a valid instruction at ID
- idu_dispatcher_stall_vld  in  1  load-use hazard from the bypass MUX
- idu_dispatcher_wfi_vld  in  1  decoded WFI
- idu_dispatcher_exception_illegal_inst  in  1  decoded illegal instruction
- idu_dispatcher_rd_vld  in  1  decoded instruction writes rd
- idu_dispatcher_dmem_load  in  1  decoded load
- iex_dispatcher_flush  in  1  taken branch or jump resolved in EX; ID holds a wrong-path instruction
- irq_dispatcher_wakeup  in  1  wake-up event for WFI
- dispatcher_instBuffer_pop  out  1  combinational; consume the ID instruction this cycle
- dispatcher_ifu_pc_hold  out  1  combinational; freeze PC and buffer
- dispatcher_iex_pipe_vld  out  1  registered; EX holds a valid instruction
- dispatcher_iex_rd_vld  out  1  registered; EX instruction writes rd (0 when pipe_vld=0)
- dispatcher_iex_is_load  out  1  registered; EX instruction is a load (0 when pipe_vld=0)
- dispatcher_wfi_sleep  out  1  registered; state==WFI
- dispatcher_exception_vld  out  1  registered; sticky, state==HALT
- dispatcher_perf_issue_cnt  out  CNT_WIDTH  instructions issued
- dispatcher_perf_stall_cnt  out  CNT_WIDTH  load-use stall cycles

## Operation
- States (2-bit encoding): RUN=0, WFI=1, HALT=2. Encoding 3 is illegal and recovers to RUN.
- The RUN state evaluates the following per cycle, in strict priority order:
  1. flush: pop=inst_vld, bubble, stay RUN. Stall, wfi and illegal are ignored.
  2. !inst_vld: pop=0, bubble, stay RUN.
  3. illegal_inst: pop=0, bubble, next=HALT.
  4. stall_vld: pop=0, pc_hold=1, bubble, stall_cnt+1.
  5. wfi_vld: pop=1, bubble (WFI retires as a no-op), next=WFI.
  6. otherwise: issue. pop=1, pipe_vld<=1, rd_vld<=idu rd_vld, is_load<=dmem_load, issue_cnt+1.
- Bubble means that on the next edge pipe_vld, rd_vld and is_load are all 0.
- pc_hold=1 whenever pop=0 and inst_vld=1, and always in WFI and HALT.
- WFI state: pop=0, bubble every cycle. irq_dispatcher_wakeup -> RUN on the next edge. flush is ignored in WFI because no older instruction remains in EX.
- HALT state: pop=0, bubble, exception_vld=1. Only reset leaves HALT.
- Counters are unsigned and saturate at 2^CNT_WIDTH-1; they never wrap.

## Timing
- Reset values (rst_n=0 at an edge): state=RUN, pipe_vld=0, rd_vld=0, is_load=0, wfi_sleep=0, exception_vld=0, both counters=0.
- Reset wins over every other input at that edge, including mid-WFI and in HALT.
- pop and pc_hold are combinational from the current-cycle inputs and state; there is no registered path.
- Issue latency: the instruction popped in cycle N appears as pipe_vld=1 in cycle N+1.
- Load-use stall: stall_vld is asserted while the load is in EX. The dependent instruction is held one cycle, then issues once stall_vld drops.
- WFI: decoded in cycle N; wfi_sleep=1 from N+1. Minimum residency is one cycle, because wakeup is sampled only in WFI. A wakeup at N is lost; a wakeup at N+1 returns to RUN at N+2.
- Illegal: decoded in cycle N; exception_vld=1 from N+1. The illegal instruction is never popped and never issued.
- Simultaneous flush and illegal, or flush and wfi: flush wins and the state stays RUN.
- Counter updates take effect at the same edge as the event.

## Test plan
- Reset, then 4 back-to-back valid ALU instructions with rd_vld=1 -> pop=1 in each of the 4 cycles; pipe_vld=1 in cycles 2-5; issue_cnt=4; stall_cnt=0.
- Load (dmem_load=1) followed by a dependent instruction with stall_vld=1 for 1 cycle -> is_load=1 in EX; dependent instruction sees pop=0, pc_hold=1, a bubble, then issues; stall_cnt=1; issue_cnt=2.
- WFI with wakeup pulsed 3 cycles later -> wfi_sleep=1 for 3 cycles, no issue during sleep, RUN resumes the next cycle, and the next instruction issues.
- Illegal instruction with flush=0 -> exception_vld=1 next cycle and sticky for 10 further cycles with inst_vld=1; issue_cnt unchanged; rst_n=0 for one edge clears it to 0.
- flush together with illegal_inst, then flush together with wfi_vld -> state remains RUN, pop=1 both cycles, pipe_vld=0, exception_vld=0, wfi_sleep=0.
- CNT_WIDTH=4, 20 consecutive issues -> issue_cnt saturates at 15; apply reset in a cycle where a stall is also asserted -> all outputs equal their reset values at the next cycle.
